// File: rtl/isp_crop_window_if.sv
// Pixel stream bundle (line valid, frame sync, packed pixel data) shared by
// the crop stage input and output.
interface isp_crop_window_if #(
   parameter int DATA_W = 8
);
   logic              href;
   logic              vsync;
   logic [DATA_W-1:0] data;

   modport master (output href, vsync, data);
   modport slave  (input  href, vsync, data);
endinterface

// File: rtl/isp_crop_window.sv
// Runtime crop window with integer decimation for the ISP pixel stream.
// Config is shadowed per frame; the incoming frame size is measured and checked.
module isp_crop_window #(
   parameter int BITS     = 8,
   parameter int CHANNELS = 1,
   parameter int CNT_W    = 13,
   parameter int DEC_W    = 3
) (
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic                 crop_en,
   input  logic [CNT_W-1:0]     win_x,
   input  logic [CNT_W-1:0]     win_y,
   input  logic [CNT_W-1:0]     win_w,
   input  logic [CNT_W-1:0]     win_h,
   input  logic [DEC_W-1:0]     hdec,
   input  logic [DEC_W-1:0]     vdec,
   isp_crop_window_if.slave     in_s,
   isp_crop_window_if.master    out_m,
   output logic [CNT_W-1:0]     frame_width,
   output logic [CNT_W-1:0]     frame_height,
   output logic                 cfg_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   logic                      r_vsync_d;
   logic                      r_href_d;
   logic [CNT_W-1:0]          r_pix_cnt;
   logic [CNT_W-1:0]          r_line_cnt;
   logic [DEC_W-1:0]          r_hph;
   logic [DEC_W-1:0]          r_vph;
   logic                      r_sh_en;
   logic [CNT_W-1:0]          r_sh_x;
   logic [CNT_W-1:0]          r_sh_y;
   logic [CNT_W-1:0]          r_sh_w;
   logic [CNT_W-1:0]          r_sh_h;
   logic [DEC_W-1:0]          r_sh_hdec;
   logic [DEC_W-1:0]          r_sh_vdec;
   logic [CNT_W-1:0]          r_frame_width;
   logic [CNT_W-1:0]          r_frame_height;
   logic                      r_cfg_err;
   logic                      r_href_p1;
   logic                      r_vsync_p1;
   logic [BITS*CHANNELS-1:0]  r_data_p1;

   logic                      w_frame_start;
   logic                      w_href_rise;
   logic                      w_href_fall;
   logic [CNT_W-1:0]          w_pix_idx;
   logic [DEC_W-1:0]          w_hph;
   logic [DEC_W-1:0]          w_vph;
   logic [CNT_W:0]            w_x_end;
   logic [CNT_W:0]            w_y_end;
   logic                      w_in_h;
   logic                      w_in_v;
   logic                      w_keep;
   logic                      w_href_p0;
   logic [CNT_W-1:0]          w_fw_next;
   logic [CNT_W:0]            w_cx_end;
   logic [CNT_W:0]            w_cy_end;
   logic                      w_err_eval;

   // Stage p0: edge detection, pixel/line position and the keep decision
   assign w_frame_start = r_vsync_d & ~in_s.vsync;
   assign w_href_rise   = in_s.href & ~r_href_d;
   assign w_href_fall   = ~in_s.href & r_href_d;
   assign w_pix_idx     = w_href_rise ? '0 : r_pix_cnt;

   // Phases restart at the window origin so the first kept pixel/line is x/y
   assign w_hph = (w_pix_idx == r_sh_x) ? '0 : r_hph;
   assign w_vph = (r_line_cnt == r_sh_y) ? '0 : r_vph;

   assign w_x_end = {1'b0, r_sh_x} + {1'b0, r_sh_w};
   assign w_y_end = {1'b0, r_sh_y} + {1'b0, r_sh_h};
   assign w_in_h  = (w_pix_idx >= r_sh_x) && ({1'b0, w_pix_idx} < w_x_end);
   assign w_in_v  = (r_line_cnt >= r_sh_y) && ({1'b0, r_line_cnt} < w_y_end);
   assign w_keep  = w_in_h & w_in_v & (w_hph == '0) & (w_vph == '0);

   assign w_href_p0 = r_sh_en ? (in_s.href & w_keep) : in_s.href;

   // Range check uses the incoming config and the geometry measured this cycle
   assign w_fw_next  = w_href_fall ? r_pix_cnt : r_frame_width;
   assign w_cx_end   = {1'b0, win_x} + {1'b0, win_w};
   assign w_cy_end   = {1'b0, win_y} + {1'b0, win_h};
   assign w_err_eval = crop_en && (r_line_cnt != '0) &&
                       ((w_cx_end > {1'b0, w_fw_next}) || (w_cy_end > {1'b0, r_line_cnt}));

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_d      <= 1'b0;
         r_href_d       <= 1'b0;
         r_pix_cnt      <= '0;
         r_line_cnt     <= '0;
         r_hph          <= '0;
         r_vph          <= '0;
         r_sh_en        <= 1'b0;
         r_sh_x         <= '0;
         r_sh_y         <= '0;
         r_sh_w         <= '0;
         r_sh_h         <= '0;
         r_sh_hdec      <= '0;
         r_sh_vdec      <= '0;
         r_frame_width  <= '0;
         r_frame_height <= '0;
         r_cfg_err      <= 1'b0;
         r_href_p1      <= 1'b0;
         r_vsync_p1     <= 1'b0;
         r_data_p1      <= '0;
      end else begin
         r_vsync_d <= in_s.vsync;
         r_href_d  <= in_s.href;

         if (in_s.href) begin
            r_pix_cnt <= sat_inc(w_pix_idx);
            r_hph     <= (w_hph == r_sh_hdec) ? '0 : w_hph + 1'b1;
         end

         if (w_frame_start) begin
            r_line_cnt <= '0;
         end else if (w_href_fall) begin
            r_line_cnt <= sat_inc(r_line_cnt);
            r_vph      <= (w_vph == r_sh_vdec) ? '0 : w_vph + 1'b1;
         end

         if (w_href_fall) begin
            r_frame_width <= r_pix_cnt;
         end

         if (w_frame_start) begin
            r_frame_height <= r_line_cnt;
            r_sh_en        <= crop_en;
            r_sh_x         <= win_x;
            r_sh_y         <= win_y;
            r_sh_w         <= win_w;
            r_sh_h         <= win_h;
            r_sh_hdec      <= hdec;
            r_sh_vdec      <= vdec;
            r_cfg_err      <= w_err_eval;
         end

         // Stage p1: registered stream outputs
         r_href_p1  <= w_href_p0;
         r_vsync_p1 <= in_s.vsync;
         r_data_p1  <= w_href_p0 ? in_s.data : '0;
      end
   end

   assign out_m.href   = r_href_p1;
   assign out_m.vsync  = r_vsync_p1;
   assign out_m.data   = r_data_p1;
   assign frame_width  = r_frame_width;
   assign frame_height = r_frame_height;
   assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_isp_crop_window.sv
// Randomized-data bench for isp_crop_window with a frame-level reference model.
module tb_isp_crop_window;
   localparam int BITS = 8, CHANNELS = 2, CNT_W = 13, DEC_W = 3;
   localparam int DW = BITS * CHANNELS;

   logic             pclk = 1'b0;
   logic             rst_n = 1'b0;
   logic             crop_en = 1'b0;
   logic [CNT_W-1:0] win_x = '0, win_y = '0, win_w = '0, win_h = '0;
   logic [DEC_W-1:0] hdec = '0, vdec = '0;
   logic [CNT_W-1:0] frame_width, frame_height;
   logic             cfg_err;

   isp_crop_window_if #(.DATA_W(DW)) in_if ();
   isp_crop_window_if #(.DATA_W(DW)) out_if ();

   isp_crop_window #(.BITS(BITS), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .DEC_W(DEC_W)) dut (
      .pclk(pclk), .rst_n(rst_n), .crop_en(crop_en),
      .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
      .hdec(hdec), .vdec(vdec),
      .in_s(in_if), .out_m(out_if),
      .frame_width(frame_width), .frame_height(frame_height), .cfg_err(cfg_err)
   );

   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;

   // Model state: shadow config, lines since frame start, measured geometry
   int m_en = 0, m_x = 0, m_y = 0, m_w = 0, m_h = 0, m_hd = 0, m_vd = 0;
   int m_lines = 0, m_fw = 0, m_fh = 0;
   int m_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit keep(input int p, input int l);
      if (m_en == 0) return 1'b1;
      if (p < m_x || p >= m_x + m_w || l < m_y || l >= m_y + m_h) return 1'b0;
      return (((p - m_x) % (m_hd + 1)) == 0) && (((l - m_y) % (m_vd + 1)) == 0);
   endfunction

   task automatic tick(input logic h, input logic v, input bit eh);
      logic [DW-1:0] d;
      d = DW'($urandom);
      in_if.href  = h;
      in_if.vsync = v;
      in_if.data  = d;
      @(posedge pclk);
      #1;
      chk("out_href", 32'(out_if.href), 32'(eh));
      chk("out_data", 32'(out_if.data), eh ? 32'(d) : 32'h0);
      chk("out_vsync", 32'(out_if.vsync), 32'(v));
   endtask

   task automatic frame_start();
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      m_fh    = m_lines;
      m_lines = 0;
      m_en = int'(crop_en); m_x = int'(win_x); m_y = int'(win_y);
      m_w  = int'(win_w);   m_h = int'(win_h);
      m_hd = int'(hdec);    m_vd = int'(vdec);
      m_err = (m_en != 0 && m_fh != 0 && (m_x + m_w > m_fw || m_y + m_h > m_fh)) ? 1 : 0;
      tick(1'b0, 1'b0, 1'b0);
      chk("frame_height", 32'(frame_height), 32'(m_fh));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      repeat (2) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_lines(input int fw, input int fh, input int chg_line, input int chg_x);
      for (int l = 0; l < fh; l++) begin
         if (l == chg_line) win_x = CNT_W'(chg_x);
         for (int p = 0; p < fw; p++) tick(1'b1, 1'b0, keep(p, m_lines));
         m_lines++;
         m_fw = fw;
         tick(1'b0, 1'b0, 1'b0);
         chk("frame_width", 32'(frame_width), 32'(m_fw));
         repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic set_cfg(input int en, input int x, input int y, input int w, input int h,
                          input int hd, input int vd);
      crop_en = en[0];
      win_x = CNT_W'(x); win_y = CNT_W'(y); win_w = CNT_W'(w); win_h = CNT_W'(h);
      hdec = DEC_W'(hd); vdec = DEC_W'(vd);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_href"}, 32'(out_if.href), 32'h0);
      chk({tag, "_vsync"}, 32'(out_if.vsync), 32'h0);
      chk({tag, "_data"}, 32'(out_if.data), 32'h0);
      chk({tag, "_fw"}, 32'(frame_width), 32'h0);
      chk({tag, "_fh"}, 32'(frame_height), 32'h0);
      chk({tag, "_err"}, 32'(cfg_err), 32'h0);
   endtask

   initial begin
      in_if.href = 1'b0; in_if.vsync = 1'b0; in_if.data = '0;
      #12;
      check_all_zero("reset");
      @(negedge pclk);
      rst_n = 1'b1;

      // Passthrough 8x4
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      frame_start();
      run_lines(8, 4, -1, 0);

      // Plain window
      set_cfg(1, 2, 1, 4, 3, 0, 0);
      frame_start();
      run_lines(16, 8, -1, 0);

      // Window with decimation
      set_cfg(1, 1, 0, 8, 8, 1, 2);
      frame_start();
      run_lines(16, 8, -1, 0);

      // Mid-frame config change only takes effect next frame
      set_cfg(1, 2, 1, 4, 3, 0, 0);
      frame_start();
      run_lines(16, 8, 3, 5);
      frame_start();
      run_lines(16, 8, -1, 0);

      // Window past the measured width, then restored
      set_cfg(1, 10, 0, 8, 8, 0, 0);
      frame_start();
      run_lines(16, 8, -1, 0);
      win_w = CNT_W'(6);
      frame_start();
      run_lines(16, 8, -1, 0);

      // Randomized geometry and config
      for (int i = 0; i < 8; i++) begin
         int fw, fh;
         fw = $urandom_range(4, 20);
         fh = $urandom_range(2, 7);
         set_cfg($urandom_range(0, 3) != 0, $urandom_range(0, 20), $urandom_range(0, 6),
                 $urandom_range(0, 20), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 3));
         frame_start();
         run_lines(fw, fh, -1, 0);
      end

      // Reset mid-line, then passthrough until the next frame start
      set_cfg(1, 0, 0, 16, 8, 0, 0);
      frame_start();
      run_lines(16, 2, -1, 0);
      for (int p = 0; p < 5; p++) tick(1'b1, 1'b0, keep(p, m_lines));
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      in_if.href = 1'b0;
      m_en = 0; m_lines = 0; m_fw = 0; m_fh = 0; m_err = 0;
      @(negedge pclk);
      rst_n = 1'b1;
      set_cfg(1, 3, 0, 4, 2, 0, 0);
      run_lines(10, 2, -1, 0);
      frame_start();
      run_lines(10, 3, -1, 0);
      frame_start();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
